// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared types and sizes for the register-file write arbiter
package rf_arb_pkg;
    localparam int REG_ID_W = 4;
    localparam int NUM_REGS = 16;
    localparam int DATA_W   = 16;
    typedef struct packed {
        logic [REG_ID_W-1:0] reg_id;
        logic [DATA_W-1:0]   data;
    } rf_wr_t;
    typedef enum logic [1:0] {SEL_NONE, SEL_WB, SEL_AUX} arb_sel_t;
endpackage

// File: rtl/rf_write_arbiter_fifo.sv
// rf_wr_fifo: synchronous queue of write requests with full/empty flags
module rf_wr_fifo
    import rf_arb_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = rf_wr_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  T     din_i,
    input  logic pop_i,
    output T     dout_o,
    output logic full_o,
    output logic empty_o
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    T              mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= nxt(wr_q);
            end
            if (pop_i) rd_q <= nxt(rd_q);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end
    assign dout_o  = mem_q[rd_q];
    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: owns the register-file write port, WB beats a queued aux path with starvation relief
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DATA_W            = rf_arb_pkg::DATA_W,
    parameter int FIFO_DEPTH        = 2,
    parameter int STARVE_LIMIT      = 4,
    parameter bit ZERO_REG_WRITABLE = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wb_valid,
    input  logic [REG_ID_W-1:0] wb_reg,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                aux_valid,
    output logic                aux_ready,
    input  logic [REG_ID_W-1:0] aux_reg,
    input  logic [DATA_W-1:0]   aux_data,
    input  logic                aux_issue,
    input  logic [REG_ID_W-1:0] aux_issue_reg,
    output logic                WriteReg,
    output logic [REG_ID_W-1:0] DstReg,
    output logic [DATA_W-1:0]   DstData,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                wb_stall
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    typedef struct packed {
        logic [REG_ID_W-1:0] reg_id;
        logic [DATA_W-1:0]   data;
    } wr_t;
    wr_t                 aux_in, head;
    arb_sel_t            sel;
    logic                full, empty, push, pop, rdy_q, we_d, we_q, stall_d, stall_q;
    logic [REG_ID_W-1:0] sel_reg, dst_q;
    logic [DATA_W-1:0]   sel_data, data_q;
    logic [SW-1:0]       starve_q, starve_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    assign aux_in    = {aux_reg, aux_data};
    assign aux_ready = rdy_q & ~full;
    assign push      = aux_valid & aux_ready;
    assign pop       = sel == SEL_AUX;
    rf_wr_fifo #(.DEPTH(FIFO_DEPTH), .T(wr_t)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push_i(push), .din_i(aux_in), .pop_i(pop),
        .dout_o(head), .full_o(full), .empty_o(empty)
    );
    always_comb begin
        sel      = wb_valid ? SEL_WB : (empty ? SEL_NONE : SEL_AUX);
        sel_reg  = wb_valid ? wb_reg : head.reg_id;
        sel_data = wb_valid ? wb_data : head.data;
        we_d     = sel != SEL_NONE && (ZERO_REG_WRITABLE || sel_reg != '0);
        // the stall pulse restarts the count even if WB ignores it
        stall_d  = !empty && wb_valid && starve_q == SW'(STARVE_LIMIT - 1);
        starve_d = (empty || pop || stall_d) ? '0 : starve_q + 1'b1;
        busy_d   = busy_q;
        if (pop) busy_d[head.reg_id] = 1'b0;
        if (aux_issue && (ZERO_REG_WRITABLE || aux_issue_reg != '0)) busy_d[aux_issue_reg] = 1'b1;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdy_q    <= 1'b0;
            we_q     <= 1'b0;
            dst_q    <= '0;
            data_q   <= '0;
            stall_q  <= 1'b0;
            starve_q <= '0;
            busy_q   <= '0;
        end else begin
            rdy_q    <= 1'b1;
            we_q     <= we_d;
            if (we_d) begin
                dst_q  <= sel_reg;
                data_q <= sel_data;
            end
            stall_q  <= stall_d;
            starve_q <= starve_d;
            busy_q   <= busy_d;
        end
    end
    assign WriteReg  = we_q;
    assign DstReg    = dst_q;
    assign DstData   = data_q;
    assign busy_mask = busy_q;
    assign wb_stall  = stall_q;
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Owns the single write port of the 16 x 16-bit register file. It drives the port's enable, register id and data. The register file's 4-to-16 write decoder turns these into wordlines.
- Arbitrates between two requesters:
  - the pipeline writeback stage, which can never be back-pressured;
  - an auxiliary requester (multicycle/memory-return unit), which has a valid/ready handshake.
- The auxiliary path has a 2-entry queue, a starvation counter, and a per-register pending scoreboard for the hazard unit.

Parameters:
DATA_W, 16, register data width
FIFO_DEPTH, 2, auxiliary request queue depth
STARVE_LIMIT, 4, consecutive cycles an aux queue head may lose arbitration before wb_stall is raised
ZERO_REG_WRITABLE, 0, when 0 writes targeting register 0 are consumed but never reach the port

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
wb_valid  input  1  writeback stage write request; always accepted the same cycle
wb_reg  input  4  writeback destination register id
wb_data  input  DATA_W  writeback data
aux_valid  input  1  auxiliary write request valid
aux_ready  output  1  queue can accept an auxiliary request
aux_reg  input  4  auxiliary destination register id
aux_data  input  DATA_W  auxiliary data
aux_issue  input  1  multicycle op issued; mark aux_issue_reg pending
aux_issue_reg  input  4  register id to mark pending
WriteReg  output  1  register file write enable
DstReg  output  4  register file write id (decoder input)
DstData  output  DATA_W  register file write data
busy_mask  output  16  per-register pending-write scoreboard
wb_stall  output  1  request to hazard unit to insert one writeback bubble

Behaviour:
- Reset, sampled on a clk edge with rst_n=0:
  - WriteReg=0, DstReg=0, DstData=0, busy_mask=0, wb_stall=0, aux_ready=0.
  - Queue emptied, starvation counter cleared.
  - Any write held in the output register is discarded. Mid-operation reset therefore loses queued writes.
  - aux_ready=1 from the first cycle after rst_n returns high.
- Output register: WriteReg, DstReg and DstData are registered. A request selected in cycle N is presented during cycle N+1 and written into the register file at the end of N+1.
- Arbitration per cycle, with fixed priority:
  - wb_valid=1: select WB.
  - else queue non-empty: pop the head and select it.
  - else: WriteReg=0 next cycle.
- Auxiliary latency: no bypass. An aux request pushed in cycle N is eligible for pop in cycle N+1 at the earliest, so WriteReg is high at N+2 minimum.
- Queue:
  - aux_ready = not full.
  - Push on aux_valid & aux_ready.
  - Push and pop in the same cycle are allowed when not full; occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - aux_valid while aux_ready=0 is ignored; the requester must hold it.
- Starvation:
  - The counter increments each cycle the queue is non-empty and wb_valid=1.
  - It clears on any aux pop or when the queue is empty.
  - wb_stall is registered: high for one cycle when the counter reaches STARVE_LIMIT, then the counter clears.
  - Hazard unit contract: wb_valid=0 in the cycle wb_stall is high, so the aux head wins.
  - If wb_valid=1 anyway, WB still wins, nothing is dropped, and the counter restarts from 0.
- Zero register (ZERO_REG_WRITABLE=0):
  - A selected request with reg id 0, from WB or a pop, produces WriteReg=0 next cycle.
  - A popped entry is still consumed.
  - aux_issue with id 0 never sets busy_mask[0].
- Scoreboard:
  - busy_mask[r] is set the cycle after aux_issue with aux_issue_reg=r.
  - It is cleared the cycle after an aux entry with reg r is popped.
  - Set and clear of the same r in the same cycle: set wins.
  - WB writes never modify busy_mask.
- Width rules: ids are 4 bits with no range check; data passes through unmodified.

Decomposition:
- Package rf_arb_pkg:
  - REG_ID_W=4, NUM_REGS=16, DATA_W default.
  - Struct rf_wr_t {reg_id, data}.
  - Enum arb_sel_t {SEL_NONE, SEL_WB, SEL_AUX}.
- One sub-module: rf_wr_fifo, a parameterised-depth synchronous queue of rf_wr_t with full/empty.
- Arbiter, starvation counter and scoreboard stay in the top module.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with wb_valid=1 and aux_valid=1 -> all outputs 0 and aux_ready=0; one cycle after release aux_ready=1 and no spurious WriteReg.
2. WB only: wb_valid=1, wb_reg=5, wb_data=16'hBEEF in cycle N -> WriteReg=1, DstReg=5, DstData=16'hBEEF in N+1 only.
3. Aux latency and priority: aux 3/16'h1234 in cycle N (queue empty, wb idle) -> write in N+2. Repeat with wb_valid=1 (reg 7) in N+1 -> reg 7 written at N+2, reg 3 at N+3.
4. Queue full: push aux reg 1 and reg 2 while wb_valid=1 continuously -> aux_ready=0 after the second push; a third aux_valid is held and not lost. wb_stall pulses once after 4 losing cycles; with wb_valid dropped -> reg 1, reg 2, reg 3 written in order.
5. Scoreboard: aux_issue reg 9 -> busy_mask=16'h0200. Pop aux reg 9 in the same cycle as a new aux_issue reg 9 -> bit stays set. A later pop of reg 9 -> busy_mask=0.
6. Zero register: wb_reg=0 and aux reg 0 -> WriteReg stays 0, the queue entry is consumed, and busy_mask[0] never sets.
